// File: rtl/pipe_stage_ctrl.sv
// Fetch PC, IF/DE register and DE/MW control register for a 3-stage pipeline; optional perf counters under PIPE_PERF_CNT_EN.
// Latency: one cycle per stage; a redirect shows on pc_if the cycle after br_taken.
// Backpressure: stall_if holds PC and IF/DE and injects a DE/MW bubble; a stall watchdog flags stall_err.
module pipe_stage_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter int          STALL_LIMIT = 4,
  parameter int          CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_if,
  input  logic        stall_if,
  input  logic        flush_de,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [4:0]  rd_de,
  input  logic        rf_en_de,
  input  logic [1:0]  sel_wb_de,
  output logic [31:0] pc_if,
  output logic [31:0] pc_de,
  output logic [31:0] inst_de,
  output logic        valid_de,
  output logic [31:0] pc_mw,
  output logic [4:0]  rd_mw,
  output logic        rf_en_mw,
  output logic [1:0]  sel_wb_mw,
  output logic        valid_mw,
  output logic        stall_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_retired,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, STALL, REDIRECT} state_t;

  localparam logic [7:0] LIMIT8 = 8'(STALL_LIMIT);

  state_t      state_q, state_d;
  logic [31:0] pc_if_d, pc_de_d, inst_de_d, pc_mw_d;
  logic        valid_de_d, valid_mw_d, rf_en_mw_d;
  logic [4:0]  rd_mw_d;
  logic [1:0]  sel_wb_mw_d;
  logic [7:0]  stall_cnt, stall_cnt_d;
  logic        stall_err_d;
  logic        do_stall, do_flush;

  always_comb begin
    state_d     = state_q;
    pc_if_d     = pc_if;
    pc_de_d     = pc_de;
    inst_de_d   = inst_de;
    valid_de_d  = valid_de;
    pc_mw_d     = pc_de;
    rd_mw_d     = rd_de;
    rf_en_mw_d  = rf_en_de & valid_de;
    sel_wb_mw_d = sel_wb_de;
    valid_mw_d  = valid_de;
    do_stall    = 1'b0;
    do_flush    = 1'b0;

    if (state_q == BOOT) begin
      // hazard inputs are meaningless before the first fetch
      state_d     = RUN;
      pc_if_d     = RESET_PC + 32'd4;
      pc_de_d     = RESET_PC;
      inst_de_d   = inst_if;
      valid_de_d  = 1'b1;
      pc_mw_d     = '0;
      rd_mw_d     = '0;
      rf_en_mw_d  = 1'b0;
      sel_wb_mw_d = '0;
      valid_mw_d  = 1'b0;
    end else if (br_taken) begin
      state_d    = REDIRECT;
      pc_if_d    = br_target & 32'hFFFF_FFFC;
      pc_de_d    = '0;
      inst_de_d  = NOP_INST;
      valid_de_d = 1'b0;
      do_flush   = 1'b1;
    end else if (stall_if) begin
      state_d     = STALL;
      pc_mw_d     = '0;
      rd_mw_d     = '0;
      rf_en_mw_d  = 1'b0;
      sel_wb_mw_d = '0;
      valid_mw_d  = 1'b0;
      do_stall    = 1'b1;
    end else begin
      state_d = RUN;
      pc_if_d = pc_if + 32'd4;
      if (flush_de) begin
        pc_de_d    = '0;
        inst_de_d  = NOP_INST;
        valid_de_d = 1'b0;
        do_flush   = 1'b1;
      end else begin
        pc_de_d    = pc_if;
        inst_de_d  = inst_if;
        valid_de_d = 1'b1;
      end
    end

    if (do_stall) stall_cnt_d = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;
    else          stall_cnt_d = 8'd0;
    stall_err_d = stall_err | (stall_cnt_d >= LIMIT8);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_if     <= RESET_PC;
      pc_de     <= '0;
      inst_de   <= NOP_INST;
      valid_de  <= 1'b0;
      pc_mw     <= '0;
      rd_mw     <= '0;
      rf_en_mw  <= 1'b0;
      sel_wb_mw <= '0;
      valid_mw  <= 1'b0;
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_if     <= pc_if_d;
      pc_de     <= pc_de_d;
      inst_de   <= inst_de_d;
      valid_de  <= valid_de_d;
      pc_mw     <= pc_mw_d;
      rd_mw     <= rd_mw_d;
      rf_en_mw  <= rf_en_mw_d;
      sel_wb_mw <= sel_wb_mw_d;
      valid_mw  <= valid_mw_d;
      stall_cnt <= stall_cnt_d;
      stall_err <= stall_err_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_retired <= '0;
      cnt_stall   <= '0;
      cnt_flush   <= '0;
    end else begin
      if (valid_mw) cnt_retired <= cnt_retired + 1'b1;
      if (do_stall) cnt_stall   <= cnt_stall + 1'b1;
      if (do_flush) cnt_flush   <= cnt_flush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: directed hazard scenarios then random hazards against a reference model.
module tb_pipe_stage_ctrl;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_if = '0, br_target = '0;
  logic        stall_if = 1'b0, flush_de = 1'b0, br_taken = 1'b0, rf_en_de = 1'b0;
  logic [4:0]  rd_de = '0;
  logic [1:0]  sel_wb_de = '0;
  logic [31:0] pc_if, pc_de, inst_de, pc_mw;
  logic        valid_de, rf_en_mw, valid_mw, stall_err;
  logic [4:0]  rd_mw;
  logic [1:0]  sel_wb_mw;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cnt_retired, cnt_stall, cnt_flush;
  int unsigned m_cr, m_cs, m_cf;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state: one slot per pipeline stage
  logic [31:0] m_pc, m_pc_de, m_inst_de, m_pc_mw;
  logic        m_v_de, m_v_mw, m_rf_mw, m_err, m_boot;
  logic [4:0]  m_rd_mw;
  logic [1:0]  m_sel_mw;
  int          m_scnt;

  pipe_stage_ctrl #(.RESET_PC(RPC), .NOP_INST(NOP), .STALL_LIMIT(LIMIT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .inst_if(inst_if), .stall_if(stall_if), .flush_de(flush_de),
    .br_taken(br_taken), .br_target(br_target), .rd_de(rd_de), .rf_en_de(rf_en_de),
    .sel_wb_de(sel_wb_de), .pc_if(pc_if), .pc_de(pc_de), .inst_de(inst_de), .valid_de(valid_de),
    .pc_mw(pc_mw), .rd_mw(rd_mw), .rf_en_mw(rf_en_mw), .sel_wb_mw(sel_wb_mw), .valid_mw(valid_mw),
    .stall_err(stall_err)
`ifdef PIPE_PERF_CNT_EN
    , .cnt_retired(cnt_retired), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_pc_de = '0; m_inst_de = NOP; m_v_de = 1'b0;
    m_pc_mw = '0; m_rd_mw = '0; m_rf_mw = 1'b0; m_sel_mw = '0; m_v_mw = 1'b0;
    m_err = 1'b0; m_scnt = 0; m_boot = 1'b1;
`ifdef PIPE_PERF_CNT_EN
    m_cr = 0; m_cs = 0; m_cf = 0;
`endif
  endtask

  task automatic mw_bubble();
    m_pc_mw = '0; m_rd_mw = '0; m_rf_mw = 1'b0; m_sel_mw = '0; m_v_mw = 1'b0;
  endtask

  task automatic mw_take_de();
    m_pc_mw = m_pc_de; m_rd_mw = rd_de; m_rf_mw = rf_en_de & m_v_de;
    m_sel_mw = sel_wb_de; m_v_mw = m_v_de;
  endtask

  // advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
`ifdef PIPE_PERF_CNT_EN
    if (m_v_mw) m_cr++;
`endif
    if (m_boot) begin
      mw_bubble();
      m_pc_de = RPC; m_inst_de = inst_if; m_v_de = 1'b1;
      m_pc = RPC + 32'd4; m_scnt = 0; m_boot = 1'b0;
    end else if (br_taken) begin
      mw_take_de();
      m_pc_de = '0; m_inst_de = NOP; m_v_de = 1'b0;
      m_pc = {br_target[31:2], 2'b00}; m_scnt = 0;
`ifdef PIPE_PERF_CNT_EN
      m_cf++;
`endif
    end else if (stall_if) begin
      mw_bubble();
      if (m_scnt < 255) m_scnt++;
`ifdef PIPE_PERF_CNT_EN
      m_cs++;
`endif
    end else begin
      mw_take_de();
      if (flush_de) begin
        m_pc_de = '0; m_inst_de = NOP; m_v_de = 1'b0;
`ifdef PIPE_PERF_CNT_EN
        m_cf++;
`endif
      end else begin
        m_pc_de = m_pc; m_inst_de = inst_if; m_v_de = 1'b1;
      end
      m_pc = m_pc + 32'd4; m_scnt = 0;
    end
    if (m_scnt >= LIMIT) m_err = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_if"}, pc_if, m_pc);
    chk({tag, ".pc_de"}, pc_de, m_pc_de);
    chk({tag, ".inst_de"}, inst_de, m_inst_de);
    chk({tag, ".valid_de"}, 32'(valid_de), 32'(m_v_de));
    chk({tag, ".valid_mw"}, 32'(valid_mw), 32'(m_v_mw));
    chk({tag, ".rd_mw"}, 32'(rd_mw), 32'(m_rd_mw));
    chk({tag, ".rf_en_mw"}, 32'(rf_en_mw), 32'(m_rf_mw));
    chk({tag, ".sel_wb_mw"}, 32'(sel_wb_mw), 32'(m_sel_mw));
    chk({tag, ".stall_err"}, 32'(stall_err), 32'(m_err));
    if (m_v_mw) chk({tag, ".pc_mw"}, pc_mw, m_pc_mw);
`ifdef PIPE_PERF_CNT_EN
    chk({tag, ".cnt_retired"}, cnt_retired, m_cr);
    chk({tag, ".cnt_stall"}, cnt_stall, m_cs);
    chk({tag, ".cnt_flush"}, cnt_flush, m_cf);
`endif
  endtask

  task automatic cyc(input logic st, input logic fl, input logic br, input logic [31:0] tgt);
    stall_if = st; flush_de = fl; br_taken = br; br_target = tgt;
    inst_if = $urandom; rd_de = 5'($urandom); rf_en_de = 1'($urandom); sel_wb_de = 2'($urandom);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(7) == 0, $urandom);
  endtask

  initial begin
    model_reset();
    do_reset();

    // reset release, straight-line flow
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("flow.valid_mw", 32'(valid_mw), 32'd1);
    chk("flow.pc_mw", pc_mw, 32'h0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("flow.pc_if", pc_if, 32'h10);

    // two-cycle load-use stall
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("stall.pc_if", pc_if, 32'h10);
    chk("stall.valid_mw", 32'(valid_mw), 32'd0);
    cyc(0, 0, 0, 0);
    chk("stall.resume", pc_if, 32'h14);
    chk("stall.err", 32'(stall_err), 32'd0);

    // redirect from 0x20 to 0x103 (aligned down)
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("br.pre_pc", pc_if, 32'h20);
    cyc(0, 0, 1, 32'h103);
    chk("br.pc_if", pc_if, 32'h100);
    chk("br.inst_de", inst_de, 32'h13);
    chk("br.valid_de", 32'(valid_de), 32'd0);
    chk("br.valid_mw", 32'(valid_mw), 32'd1);

    // redirect beats a simultaneous stall
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 32'h200);
    chk("brst.pc_if", pc_if, 32'h200);
    chk("brst.valid_mw", 32'(valid_mw), 32'd1);
    chk("brst.pc_mw", pc_mw, 32'h100);

    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // watchdog: five stall cycles
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("wd.err3", 32'(stall_err), 32'd0);
    cyc(1, 0, 0, 0);
    chk("wd.err4", 32'(stall_err), 32'd1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("wd.sticky", 32'(stall_err), 32'd1);

    // PC wraps modulo 2^32
    cyc(0, 0, 1, 32'hFFFF_FFFE);
    chk("wrap.pre", pc_if, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("wrap.pc_if", pc_if, 32'h0);

    rand_run(300);

    // async reset in the middle of a stall at pc 0x40
    do_reset();
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0);
    chk("arst.pre_pc", pc_if, 32'h40);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    chk("arst.pc_if", pc_if, RPC);
    chk("arst.err", 32'(stall_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 1, 1, 32'h500);
    chk("arst.boot_pc", pc_if, RPC + 32'd4);
    chk("arst.boot_valid", 32'(valid_de), 32'd1);

    rand_run(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
- Consumer of the hazard unit's stall, flush and branch signals in the 3-stage RISC-V pipeline (IF, DE, MW).
- Owns the fetch PC register, the IF/DE pipeline register and the control half of the DE/MW register.
- Applies hold, bubble and redirect actions each cycle, and tracks persistent stalls with a watchdog.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).
- STALL_LIMIT, 4, maximum consecutive stall cycles before stall_err is set (1..255).
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- inst_if  in  32  instruction read from imem at pc_if
- stall_if  in  1  hold IF and IF/DE (load-use)
- flush_de  in  1  bubble request from hazard unit
- br_taken  in  1  branch/jump resolved taken in DE
- br_target  in  32  redirect address
- rd_de  in  5  destination register of the instruction in DE
- rf_en_de  in  1  regfile write enable of the instruction in DE
- sel_wb_de  in  2  writeback select of the instruction in DE
- pc_if  out  32  fetch address to imem
- pc_de  out  32  PC of the instruction in DE
- inst_de  out  32  instruction in DE
- valid_de  out  1  DE holds a real instruction
- pc_mw  out  32  PC of the instruction in MW
- rd_mw  out  5  destination register in MW
- rf_en_mw  out  1  regfile write enable in MW, gated by valid_mw
- sel_wb_mw  out  2  writeback select in MW
- valid_mw  out  1  MW holds a real instruction
- stall_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async, any cycle, including mid-stall or mid-redirect) forces the following values immediately:
  - pc_if=RESET_PC, pc_de=pc_mw=0, inst_de=NOP_INST.
  - valid_de=valid_mw=0, rd_mw=0, rf_en_mw=0, sel_wb_mw=0.
  - stall_err=0, stall counter=0, state=BOOT.
- FSM states: BOOT, RUN, STALL, REDIRECT. Registered, updated on each rising clk.
  - BOOT: lasts exactly one cycle after reset release. Inputs are ignored. pc_if advances to RESET_PC+4 and IF/DE captures {RESET_PC, inst_if, valid=1}. Next state is RUN.
  - RUN, STALL and REDIRECT apply the per-cycle priority below. Next state:
    - REDIRECT if br_taken=1.
    - else STALL if stall_if=1.
    - else RUN.
- Per-cycle priority (evaluated outside BOOT):
  1. br_taken=1:
     - pc_if <= {br_target[31:2],2'b00}.
     - IF/DE <= {pc=0, inst=NOP_INST, valid=0}.
     - DE/MW <= DE contents normally. The branch itself retires.
     - stall_if and flush_de are ignored.
  2. stall_if=1:
     - pc_if and IF/DE hold.
     - DE/MW <= bubble (valid_mw=0, rf_en_mw=0, rd_mw=0, sel_wb_mw=0). This applies regardless of flush_de.
  3. flush_de=1 alone:
     - pc_if <= pc_if+4.
     - IF/DE <= NOP bubble.
     - DE/MW <= DE contents.
  4. Normal operation:
     - pc_if <= pc_if+4.
     - IF/DE <= {pc_if, inst_if, 1}.
     - DE/MW <= {pc_de, rd_de, rf_en_de & valid_de, sel_wb_de, valid_de}.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Stall watchdog:
  - An 8-bit counter increments on each cycle with stall_if=1 and br_taken=0. It clears on any other cycle.
  - When the counter reaches STALL_LIMIT, stall_err is set on that edge and stays set until rst.
  - The counter saturates at 255.
- Latency: IF/DE and DE/MW each add one cycle. A redirect is visible on pc_if the cycle after br_taken.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, three extra outputs are present: cnt_retired, cnt_stall and cnt_flush, each CNT_W wide.
  - Each resets to 0 and wraps on overflow.
  - cnt_retired increments when valid_mw=1.
  - cnt_stall increments on each cycle where priority 2 is applied.
  - cnt_flush increments on each cycle where priority 1 or 3 is applied.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, no hazards, inst_if=incrementing values, 4 cycles:
  - pc_if sequence is 0, 4, 8, 12, 16.
  - valid_de=1 from cycle 1; valid_mw=1 from cycle 2 with pc_mw=0.
- stall_if=1 for 2 cycles with pc_if=0x10:
  - pc_if and inst_de hold for 2 cycles.
  - valid_mw=0 and rf_en_mw=0 for 2 cycles.
  - Flow resumes at 0x14 and stall_err stays 0.
- br_taken=1 with br_target=0x103 while pc_if=0x20:
  - Next cycle pc_if=0x100, inst_de=0x00000013, valid_de=0.
  - The branch appears in MW with valid_mw=1.
- br_taken=1 and stall_if=1 in the same cycle:
  - Redirect wins: pc_if=br_target, and DE/MW receives the DE instruction, not a bubble.
- stall_if held 5 cycles with STALL_LIMIT=4: stall_err=1 after the 4th edge, still 1 after stall drops, cleared only by rst.
- rst asserted mid-stall while pc_if=0x40: all outputs take reset values immediately, without waiting for a clock edge. After release, state goes through BOOT and pc_if=RESET_PC.
